// File: rtl/fas_pkg.sv
// Shared constants and FSM state type for the FAS frame scheduler.
package fas_pkg;

  localparam int unsigned FAS_DW    = 16;
  localparam int unsigned FAS_MW    = 32;
  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StHalt
  } fas_state_e;

endpackage

// File: rtl/fas_pingpong_buf.sv
// Two-bank frame buffer: one write port, one registered read port (1-cycle latency).
module fas_pingpong_buf
  import fas_pkg::*;
#(
  parameter int unsigned DW = FAS_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0] mem [2][FRAME_LEN];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/fas_frame_ctrl.sv
// Packs FIR samples into ping-pong frames, sequences the shared FFT engine and tracks the peak bin.
// Define FAS_DC_SKIP_EN to exclude bin 0 from peak tracking.
module fas_frame_ctrl
  import fas_pkg::*;
#(
  parameter int unsigned DW         = FAS_DW,
  parameter int unsigned MW         = FAS_MW,
  parameter int unsigned NUM_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  input  logic [DW-1:0]    fir_d,
  output logic             fft_start,
  output logic             fft_bank,
  input  logic             fft_busy,
  input  logic [IDX_W-1:0] buf_rd_addr,
  output logic [DW-1:0]    buf_rd_data,
  input  logic             bin_valid,
  input  logic [IDX_W-1:0] bin_idx,
  input  logic [MW-1:0]    bin_mag,
  output logic [6:0]       frame_cnt,
  output logic             overrun,
  output logic             done,
  output logic [IDX_W-1:0] freq
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

  fas_state_e       state_q, state_d;
  logic             wr_bank_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [1:0]       full_q, full_d;
  logic             rd_bank_q;
  logic             fft_bank_q;
  logic             busy_seen_q;
  logic [MW-1:0]    peak_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [6:0]       frame_cnt_q;
  logic             overrun_q;
  logic [IDX_W-1:0] freq_q;

  logic release_frame;
  logic bank_free;
  logic accept;
  logic last_frame;
  logic bin_elig;
  logic bin_hit;

  // Engine finished: busy was seen high and has now dropped.
  assign release_frame = (state_q == StRun) && busy_seen_q && !fft_busy;
  // A bank released this very cycle is already free for the writer.
  assign bank_free  = !full_q[wr_bank_q] || (release_frame && (fft_bank_q == wr_bank_q));
  assign accept     = fir_valid && bank_free;
  assign last_frame = (32'(frame_cnt_q) + 32'd1) == NUM_FRAMES;

`ifdef FAS_DC_SKIP_EN
  assign bin_elig = (bin_idx != '0);
`else
  assign bin_elig = 1'b1;
`endif
  assign bin_hit = bin_valid && bin_elig && (bin_mag > peak_q);

  fas_pingpong_buf #(
    .DW(DW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (accept),
    .wr_bank (wr_bank_q),
    .wr_idx  (wr_idx_q),
    .wr_data (fir_d),
    .rd_bank (fft_bank_q),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  // Writer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      overrun_q <= 1'b0;
    end else if (fir_valid) begin
      if (bank_free) begin
        if (wr_idx_q == LastIdx) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + 1'b1;
        end
      end else begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (release_frame) begin
      full_d[fft_bank_q] = 1'b0;
    end
    if (accept && (wr_idx_q == LastIdx)) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      full_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (full_q[rd_bank_q]) state_d = StStart;
      StStart: state_d = StRun;
      StRun:   if (release_frame) state_d = last_frame ? StHalt : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fft_start = (state_q == StStart);
    done      = (state_q == StHalt);
  end

  // Frame sequencing and peak tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q   <= 1'b0;
      fft_bank_q  <= 1'b0;
      busy_seen_q <= 1'b0;
      peak_q      <= '0;
      peak_idx_q  <= '0;
      frame_cnt_q <= '0;
      freq_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          peak_q      <= '0;
          peak_idx_q  <= '0;
          busy_seen_q <= 1'b0;
          if (full_q[rd_bank_q]) begin
            fft_bank_q <= rd_bank_q;
          end
        end
        StStart: begin
          if (fft_busy) busy_seen_q <= 1'b1;
        end
        StRun: begin
          if (fft_busy) busy_seen_q <= 1'b1;
          if (bin_hit) begin
            peak_q     <= bin_mag;
            peak_idx_q <= bin_idx;
          end
          if (release_frame) begin
            busy_seen_q <= 1'b0;
            rd_bank_q   <= ~rd_bank_q;
            frame_cnt_q <= frame_cnt_q + 7'd1;
            if (last_frame) begin
              freq_q <= peak_idx_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign fft_bank  = fft_bank_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign freq      = freq_q;

endmodule

// File: tb/tb_fas_frame_ctrl.sv
// Directed + randomized bench for fas_frame_ctrl with a behavioural engine and peak model.
`timescale 1ns/1ps
module tb_fas_frame_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned MW = 32;
  localparam int unsigned NF = 3;
`ifdef FAS_DC_SKIP_EN
  localparam bit DcSkip = 1'b1;
`else
  localparam bit DcSkip = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          fft_start;
  logic          fft_bank;
  logic          fft_busy;
  logic [3:0]    buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic          bin_valid;
  logic [3:0]    bin_idx;
  logic [MW-1:0] bin_mag;
  logic [6:0]    frame_cnt;
  logic          overrun;
  logic          done;
  logic [3:0]    freq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] samp [$];
  logic [MW-1:0] mag_t [16];
  logic [3:0]    ord_t [16];

  always #5 clk = ~clk;

  fas_frame_ctrl #(
    .DW(DW),
    .MW(MW),
    .NUM_FRAMES(NF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .fft_start   (fft_start),
    .fft_bank    (fft_bank),
    .fft_busy    (fft_busy),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .bin_valid   (bin_valid),
    .bin_idx     (bin_idx),
    .bin_mag     (bin_mag),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .done        (done),
    .freq        (freq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; fir_valid = 1'b0; fir_d = '0; fft_busy = 1'b0;
    buf_rd_addr = '0; bin_valid = 1'b0; bin_idx = '0; bin_mag = '0;
    samp.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 32'(fft_start), 32'd0);
    check({tag, "_bank"},  32'(fft_bank),  32'd0);
    check({tag, "_rd"},    32'(buf_rd_data), 32'd0);
    check({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    check({tag, "_ovr"},   32'(overrun),   32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_freq"},  32'(freq),      32'd0);
  endtask

  // Feeds n random samples, one every gap cycles; every sample is logged.
  task automatic stream(input int n, input int gap);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom) | DW'(1);
      fir_valid = 1'b1;
      fir_d = v;
      samp.push_back(v);
      tick();
      for (int g = 1; g < gap; g++) begin
        fir_valid = 1'b0;
        tick();
      end
    end
    fir_valid = 1'b0;
  endtask

  // mode 0: random mags/arrival order, 1: symmetric 1/15, 2: DC-heavy
  task automatic fill_bins(input int mode);
    logic [3:0] t;
    int j;
    for (int k = 0; k < 16; k++) begin
      ord_t[k] = 4'(k);
      mag_t[k] = (mode == 0) ? MW'($urandom_range(0, 7)) : (mode == 1) ? 32'h10 : 32'h0;
    end
    if (mode == 0) begin
      for (int k = 15; k > 0; k--) begin
        j = $urandom_range(0, k);
        t = ord_t[k]; ord_t[k] = ord_t[j]; ord_t[j] = t;
      end
    end
    if (mode == 1) begin mag_t[1] = 32'h500; mag_t[15] = 32'h500; end
    if (mode == 2) begin mag_t[0] = 32'hFFFF; mag_t[3] = 32'h20; end
  endtask

  // Largest eligible magnitude wins; among equals the first to arrive wins; all-zero gives 0.
  function automatic logic [3:0] ref_peak();
    logic [MW-1:0] top = '0;
    for (int k = 0; k < 16; k++)
      if (!(DcSkip && k == 0) && mag_t[k] > top) top = mag_t[k];
    if (top == '0) return 4'd0;
    for (int j = 0; j < 16; j++)
      if (!(DcSkip && ord_t[j] == 4'd0) && mag_t[ord_t[j]] == top) return ord_t[j];
    return 4'd0;
  endfunction

  task automatic wait_start(input string tag);
    int t = 0;
    while (fft_start !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    check({tag, "_start"}, 32'(fft_start), 32'd1);
  endtask

  // Behavioural engine: one frame; mode < 0 presents no bins, base < 0 skips read checks.
  task automatic engine(input string tag, input int busy, input int mode, input bit exp_bank,
                        input int base);
    wait_start(tag);
    check({tag, "_bank"}, 32'(fft_bank), 32'(exp_bank));
    if (mode >= 0) fill_bins(mode);
    fft_busy = 1'b1;
    for (int k = 0; k < busy; k++) begin
      buf_rd_addr = 4'(k);
      bin_valid = (mode >= 0) && (k >= 1) && (k <= 16);
      if (k >= 1 && k <= 16) begin
        bin_idx = ord_t[k-1];
        bin_mag = mag_t[ord_t[k-1]];
      end
      tick();
      if (k == 0) check({tag, "_pulse"}, 32'(fft_start), 32'd0);
      if (k < 16 && base >= 0) check({tag, "_rd"}, 32'(buf_rd_data), 32'(samp[base+k]));
    end
    fft_busy = 1'b0;
    bin_valid = 1'b0;
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int starts;

    // Basic frame with directed data
    do_reset();
    check_reset_vals("rst0");
    for (int i = 0; i < 16; i++) begin
      fir_valid = 1'b1;
      fir_d = 16'h0100 + 16'(i);
      tick();
    end
    fir_valid = 1'b0;
    check("t1_nostart", 32'(fft_start), 32'd0);
    tick();
    check("t1_start", 32'(fft_start), 32'd1);
    check("t1_bank", 32'(fft_bank), 32'd0);
    fft_busy = 1'b1;
    buf_rd_addr = 4'd5;
    tick();
    check("t1_pulse", 32'(fft_start), 32'd0);
    check("t1_rd5", 32'(buf_rd_data), 32'h0105);
    repeat (18) tick();
    fft_busy = 1'b0;
    tick();
    check("t1_fcnt", 32'(frame_cnt), 32'd1);
    check("t1_done", 32'(done), 32'd0);

    // Ping-pong with random data and random bins
    do_reset();
    fork
      stream(48, 2);
      begin
        engine("pp0", 24, 0, 1'b0, 0);
        check("pp0_fcnt", 32'(frame_cnt), 32'd1);
        engine("pp1", 24, 0, 1'b1, 16);
        check("pp1_fcnt", 32'(frame_cnt), 32'd2);
        engine("pp2", 24, 0, 1'b0, 32);
      end
    join
    check("pp_fcnt", 32'(frame_cnt), 32'd3);
    check("pp_done", 32'(done), 32'd1);
    check("pp_freq", 32'(freq), 32'(ref_peak()));
    check("pp_ovr", 32'(overrun), 32'd0);

    // HALT: samples still land, no new starts
    starts = 0;
    fork
      stream(32, 1);
      for (int c = 0; c < 40; c++) begin
        tick();
        if (fft_start === 1'b1) starts++;
      end
    join
    check("halt_nostart", 32'(starts), 32'd0);
    check("halt_ovr0", 32'(overrun), 32'd0);
    stream(1, 1);
    check("halt_ovr1", 32'(overrun), 32'd1);
    check("halt_done", 32'(done), 32'd1);

    // Symmetric spectrum in the final frame
    do_reset();
    fork
      stream(48, 2);
      begin
        engine("sy0", 20, 0, 1'b0, 0);
        engine("sy1", 20, 0, 1'b1, 16);
        engine("sy2", 20, 1, 1'b0, 32);
      end
    join
    check("sy_done", 32'(done), 32'd1);
    check("sy_freq", 32'(freq), 32'd1);

    // DC-dominated final frame
    do_reset();
    fork
      stream(48, 2);
      begin
        engine("dc0", 20, 0, 1'b0, 0);
        engine("dc1", 20, 0, 1'b1, 16);
        engine("dc2", 20, 2, 1'b0, 32);
      end
    join
    check("dc_freq", 32'(freq), DcSkip ? 32'd3 : 32'd0);
    check("dc_model", 32'(freq), 32'(ref_peak()));

    // Overrun: slow engine, 33rd sample onwards dropped, write index held
    do_reset();
    fork
      begin
        stream(32, 1);
        check("ov_pre", 32'(overrun), 32'd0);
        stream(1, 1);
        check("ov_set", 32'(overrun), 32'd1);
        stream(15, 1);
        repeat (30) tick();
        stream(16, 1);
      end
      begin
        engine("ov0", 40, -1, 1'b0, 0);
        engine("ov1", 20, -1, 1'b1, 16);
        engine("ov2", 20, 0, 1'b0, 48);
      end
    join
    check("ov_sticky", 32'(overrun), 32'd1);
    check("ov_fcnt", 32'(frame_cnt), 32'd3);
    check("ov_done", 32'(done), 32'd1);
    check("ov_freq", 32'(freq), 32'(ref_peak()));

    // Reset in the middle of a RUN on bank 1
    do_reset();
    fork
      stream(33, 1);
      begin
        engine("rs0", 22, -1, 1'b0, 0);
        wait_start("rs1");
        check("rs1_bank", 32'(fft_bank), 32'd1);
        fft_busy = 1'b1;
        buf_rd_addr = 4'd3;
        tick();
        tick();
        tick();
      end
    join
    check("rs_pre_ovr", 32'(overrun), 32'd1);
    check("rs_pre_fcnt", 32'(frame_cnt), 32'd1);
    check("rs_pre_rd", 32'(buf_rd_data), 32'(samp[19]));
    rst = 1'b1;
    tick();
    check_reset_vals("rs_mid");
    rst = 1'b0;
    fft_busy = 1'b0;
    fork
      stream(16, 1);
      engine("rs2", 20, 0, 1'b0, 33);
    join
    check("rs_fcnt", 32'(frame_cnt), 32'd1);
    check("rs_ovr", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
